// File: rtl/xor_stream_pkg.sv
// Shared definitions for the XOR bit-stream blocks: FSM state constants
// and the largest frame length the accumulator supports.
package xor_stream_pkg;

  typedef logic state_t;

  localparam state_t ST_ACCUM = 1'b0;
  localparam state_t ST_HOLD  = 1'b1;

  localparam int FRAME_LEN_MAX = 32;

endpackage

// File: rtl/xor_parity_cell.sv
// One-bit registered XOR accumulator. While en is high, d is folded into q.
// A synchronous clr returns q to zero and takes priority over en.
module xor_parity_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  // Running parity register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/xor_parity_accumulator.sv
// Collects the XOR gate's serial output into FRAME_LEN-bit frames (LSB first)
// and offers each frame plus its parity on a valid/ready interface.
// FRAME_LEN must lie in 2..FRAME_LEN_MAX.
module xor_parity_accumulator
  import xor_stream_pkg::*;
#(
  parameter  int FRAME_LEN  = 8,
  parameter  bit PARITY_ODD = 1'b0,
  localparam int CNT_W      = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_parity,
  input  logic                 out_ready
);

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     count_reg;
  logic [FRAME_LEN-1:0] shift_reg;
  logic [FRAME_LEN-1:0] shift_next;
  logic [FRAME_LEN-1:0] out_data_reg;
  logic                 out_parity_reg;
  logic                 parity_q;
  logic                 accept;
  logic                 last_bit;

  assign accept   = in_valid & in_ready;
  assign last_bit = accept && (count_reg == CNT_W'(FRAME_LEN - 1));

  // Shift register image with the current bit dropped into its slot;
  // in_bit only reaches the slot addressed by the counter, and only on accept.
  generate
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_slot
      assign shift_next[gi] = (accept && (count_reg == CNT_W'(gi))) ? in_bit : shift_reg[gi];
    end
  endgenerate

  // Parity path: restarts on abort and after the last bit of each frame
  xor_parity_cell u_parity (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | last_bit),
    .en    (accept),
    .d     (in_bit),
    .q     (parity_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; clr always returns to ACCUM, dropping a held frame
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = ST_ACCUM;
    end else begin
      case (state_reg)
        ST_ACCUM: if (last_bit)              state_next = ST_HOLD;
        ST_HOLD:  if (out_valid & out_ready) state_next = ST_ACCUM;
        default:                             state_next = ST_ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_reg == ST_ACCUM);
    out_valid = (state_reg == ST_HOLD);
  end

  // Bit counter, shift register and the held output frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg      <= '0;
      shift_reg      <= '0;
      out_data_reg   <= '0;
      out_parity_reg <= 1'b0;
    end else if (clr) begin
      // Output frame keeps its last value so a dropped frame never glitches
      count_reg <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      if (last_bit) begin
        count_reg      <= '0;
        shift_reg      <= '0;
        out_data_reg   <= shift_next;
        out_parity_reg <= parity_q ^ in_bit ^ PARITY_ODD;
      end else begin
        count_reg <= count_reg + 1'b1;
        shift_reg <= shift_next;
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_parity = out_parity_reg;

endmodule

// File: tb/tb_xor_parity_accumulator.sv
// Bench for xor_parity_accumulator: an even-parity and an odd-parity instance
// share one stimulus stream and are checked each cycle against a frame model.
module tb_xor_parity_accumulator;

  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_bit;
  logic          out_ready;
  logic          in_ready_e, out_valid_e, out_parity_e;
  logic          in_ready_o, out_valid_o, out_parity_o;
  logic [FL-1:0] out_data_e, out_data_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  xor_parity_accumulator #(.FRAME_LEN(FL), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_e), .out_valid(out_valid_e), .out_data(out_data_e),
    .out_parity(out_parity_e), .out_ready(out_ready)
  );

  xor_parity_accumulator #(.FRAME_LEN(FL), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_o), .out_valid(out_valid_o), .out_data(out_data_o),
    .out_parity(out_parity_o), .out_ready(out_ready)
  );

  // Reference model: queue of accepted bits, plus the frame currently offered
  bit            m_q[$];
  bit            m_pend;
  logic [FL-1:0] m_data;
  logic          m_par_e;
  logic          m_par_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend  = 1'b0;
    m_data  = '0;
    m_par_e = 1'b0;
    m_par_o = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic v, input logic b, input logic r);
    logic [FL-1:0] f;
    if (c) begin
      m_q.delete();
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (r) m_pend = 1'b0;
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() == FL) begin
        for (int i = 0; i < FL; i++) f[i] = m_q[i];
        m_data  = f;
        m_par_e = 1'($countones(f) % 2);
        m_par_o = ~m_par_e;
        m_pend  = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready_e",   32'(in_ready_e),   32'(!m_pend));
    chk("out_valid_e",  32'(out_valid_e),  32'(m_pend));
    chk("out_data_e",   32'(out_data_e),   32'(m_data));
    chk("out_parity_e", 32'(out_parity_e), 32'(m_par_e));
    chk("in_ready_o",   32'(in_ready_o),   32'(!m_pend));
    chk("out_valid_o",  32'(out_valid_o),  32'(m_pend));
    chk("out_data_o",   32'(out_data_o),   32'(m_data));
    chk("out_parity_o", 32'(out_parity_o), 32'(m_par_o));
  endtask

  // One clock: inputs already driven, model follows the edge, outputs checked at +1
  task automatic tick();
    @(posedge clk);
    model_step(clr, in_valid, in_bit, out_ready);
    #1;
    compare_all();
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear with no clock edge
  task automatic async_reset_pulse();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid_e", 32'(out_valid_e), 32'd0);
    chk("rst_out_valid_o", 32'(out_valid_o), 32'd0);
    chk("rst_out_data_e",  32'(out_data_e),  32'd0);
    chk("rst_out_data_o",  32'(out_data_o),  32'd0);
    chk("rst_parity_e",    32'(out_parity_e), 32'd0);
    chk("rst_parity_o",    32'(out_parity_o), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [FL-1:0] bits;       // stream order: bits[0] is sent first
    bit            toggle;     // in_valid alternates 1/0
    bit            bp;         // hold out_ready low 5 cycles before handshake
    int            exp_ticks;  // edges from first drive until out_valid is seen
    logic [FL-1:0] exp_data;
    logic          exp_pe;
    logic          exp_po;
  } vec_t;

  vec_t tbl[6];

  task automatic apply_vec(input vec_t v);
    int idx  = 0;
    int seen = 0;
    for (int t = 1; t <= 40 && seen == 0; t++) begin
      clr       = 1'b0;
      out_ready = 1'b0;
      in_valid  = v.toggle ? ((t % 2) == 1) : 1'b1;
      in_bit    = (in_valid && idx < FL) ? v.bits[idx] : 1'($urandom);
      if (in_valid && idx < FL) idx++;
      tick();
      if (out_valid_e) seen = t;
    end
    in_valid = 1'b0;
    chk("latency",  32'(seen),         32'(v.exp_ticks));
    chk("data_e",   32'(out_data_e),   32'(v.exp_data));
    chk("data_o",   32'(out_data_o),   32'(v.exp_data));
    chk("parity_e", 32'(out_parity_e), 32'(v.exp_pe));
    chk("parity_o", 32'(out_parity_o), 32'(v.exp_po));
    if (v.bp) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        in_bit   = 1'($urandom);
        tick();
        chk("bp_out_valid", 32'(out_valid_e), 32'd1);
        chk("bp_in_ready",  32'(in_ready_e),  32'd0);
        chk("bp_data",      32'(out_data_e),  32'(v.exp_data));
        chk("bp_parity",    32'(out_parity_e), 32'(v.exp_pe));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid_e), 32'd0);
    chk("hs_in_ready",  32'(in_ready_e),  32'd1);
  endtask

  initial begin
    tbl[0] = '{8'h0D, 1'b0, 1'b0, 8,  8'h0D, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 1'b0, 1'b0, 8,  8'hFF, 1'b0, 1'b1};
    tbl[2] = '{8'hA5, 1'b0, 1'b1, 8,  8'hA5, 1'b0, 1'b1};
    tbl[3] = '{8'h0D, 1'b0, 1'b0, 8,  8'h0D, 1'b1, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b0, 15, 8'h07, 1'b1, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 8,  8'h3C, 1'b0, 1'b1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();

    // Reset state, before any clock edge
    #3;
    chk("reset_out_valid", 32'(out_valid_e), 32'd0);
    chk("reset_out_data",  32'(out_data_e),  32'd0);
    chk("reset_parity_o",  32'(out_parity_o), 32'd0);
    #4;
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready_e), 32'd1);

    for (int i = 0; i < 5; i++) apply_vec(tbl[i]);

    // Abort after 3 accepted bits; the bit under clr is discarded
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      tick();
    end
    clr = 1'b1; in_bit = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    apply_vec(tbl[1]);

    // Drop a held frame with clr while out_ready is also high
    for (int k = 0; k < FL; k++) begin
      in_valid = 1'b1; in_bit = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_drop_valid", 32'(out_valid_e), 32'd1);
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    chk("drop_out_valid", 32'(out_valid_e), 32'd0);
    chk("drop_in_ready",  32'(in_ready_e),  32'd1);

    // Asynchronous reset mid-frame, then again while holding a frame
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_bit = 1'($urandom);
      tick();
    end
    async_reset_pulse();
    for (int k = 0; k < FL; k++) begin
      in_valid = 1'b1; in_bit = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid_e), 32'd1);
    async_reset_pulse();
    apply_vec(tbl[5]);

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++) begin
      clr       = ($urandom_range(0, 99) < 3);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_bit    = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
